// File: rtl/truth_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_pkg
// Description : Shared types and constants for the truth-table sequencer:
//               sweep state encoding, the fxy reference table and sizing
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_pkg;

    // Default function arity and the resulting number of table rows
    localparam int N_IN_DEFAULT = 3;
    localparam int ROWS         = 1 << N_IN_DEFAULT;

    // Reference table for fxy = x & ~y with vec = {x, y, z}: rows 4 and 5 are 1
    localparam logic [ROWS-1:0] FXY_EXPECTED = 8'h30;

    // Sweep states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter width able to hold the settle reload value; at least one bit
    function automatic int settle_width(input int settle);
        int w;
        w = 1;
        while ((1 << w) <= settle) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_settle_counter.sv
`default_nettype none
// ============================================================================
// Module      : settle_counter
// Description : Per-vector settle timer. Loads the settle interval, counts
//               down to zero while enabled and flags when it has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_counter
    import truth_table_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int               c_WIDTH  = settle_width(SETTLE);
    localparam logic [c_WIDTH-1:0] c_RELOAD = c_WIDTH'(SETTLE);
    localparam logic [c_WIDTH-1:0] c_ONE    = c_WIDTH'(1);

    logic [c_WIDTH-1:0] r_count;

    // Reload wins over decrement; decrement stops at zero so the flag holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_RELOAD;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sequencer
// Description : Sweeps an N_IN-bit stimulus vector through every combination,
//               waits SETTLE extra cycles per vector, captures the function
//               output s_in and compares it with the EXPECTED truth table.
//               Reports captured table, per-row mismatch map, error count and
//               pass flag with a start/done handshake.
// Options     : TRUTH_TABLE_STOP_ON_MISMATCH_EN - end the sweep at the first
//               mismatching row (vec holds the failing vector).
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int                    N_IN     = 3,
    parameter int                    SETTLE   = 1,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = FXY_EXPECTED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] table_out,
    output logic [(1<<N_IN)-1:0] mismatch,
    output logic [N_IN:0]        err_count,
    output logic                 pass
);

    localparam int c_ROWS = 1 << N_IN;

    state_t              r_state;
    logic [N_IN-1:0]     r_idx;
    logic [N_IN-1:0]     r_vec;
    logic                r_busy;
    logic                r_done;
    logic [c_ROWS-1:0]   r_table;
    logic [c_ROWS-1:0]   r_mismatch;
    logic [N_IN:0]       r_err_count;
    logic                r_pass;

    logic                w_cnt_zero;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_row_mis;
    logic                w_last;
    logic                w_stop;
    logic                w_end;
    logic [N_IN:0]       w_err_next;

    // Row evaluation for the vector currently applied
    assign w_row_mis  = s_in ^ EXPECTED[r_idx];
    assign w_last     = &r_idx;
    assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_row_mis};

`ifdef TRUTH_TABLE_STOP_ON_MISMATCH_EN
    assign w_stop = w_row_mis;
`else
    assign w_stop = 1'b0;
`endif

    assign w_end = w_last || w_stop;

    // Settle interval restarts on sweep start and on every advance to a new row
    assign w_cnt_load = ((r_state == IDLE) && start) ||
                        ((r_state == SAMPLE) && !w_end);
    assign w_cnt_dec  = (r_state == WAIT);

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle_counter (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    // Sweep FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_table     <= '0;
            r_mismatch  <= '0;
            r_err_count <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_vec       <= '0;
                        r_table     <= '0;
                        r_mismatch  <= '0;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_table[r_idx]    <= s_in;
                    r_mismatch[r_idx] <= w_row_mis;
                    r_err_count       <= w_err_next;
                    if (w_end) begin
                        // Pass is resolved together with done so both are
                        // valid in the DONE cycle
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_vec   <= r_idx + 1'b1;
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign vec       = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
    assign pass      = r_pass;

`ifndef SYNTHESIS
    // An unknown function output at the capture edge would corrupt the table
    a_s_in_known: assert property (@(posedge clk) disable iff (reset)
        (r_state == SAMPLE) |-> !$isunknown(s_in));
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sequencer
// Description : Directed testbench for truth_table_sequencer. Two instances
//               (SETTLE=1 and SETTLE=0) share clock, reset and start; each
//               sees a function selected by `mode` applied to its own vec.
// Options     : TRUTH_TABLE_STOP_ON_MISMATCH_EN changes expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;

    logic [2:0] vec, vec0;
    logic       s_in, s_in0;
    logic       busy, busy0, done, done0, pass, pass0;
    logic [7:0] table_out, table_out0, mismatch, mismatch0;
    logic [3:0] err_count, err_count0;

    int checks   = 0;
    int failures = 0;
    logic [2:0] seen[$];

    always #5 clk = ~clk;

    // 0: fxy = x & ~y, 1: stuck at 0, 2: inverted fxy
    function automatic logic model_s(input logic [1:0] m, input logic [2:0] v);
        case (m)
            2'd0:    return v[2] & ~v[1];
            2'd1:    return 1'b0;
            default: return ~(v[2] & ~v[1]);
        endcase
    endfunction

    assign s_in  = model_s(mode, vec);
    assign s_in0 = model_s(mode, vec0);

    truth_table_sequencer #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h30)) dut (
        .clk(clk), .reset(reset), .start(start), .vec(vec), .s_in(s_in),
        .busy(busy), .done(done), .table_out(table_out), .mismatch(mismatch),
        .err_count(err_count), .pass(pass)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(0), .EXPECTED(8'h30)) dut0 (
        .clk(clk), .reset(reset), .start(start), .vec(vec0), .s_in(s_in0),
        .busy(busy0), .done(done0), .table_out(table_out0), .mismatch(mismatch0),
        .err_count(err_count0), .pass(pass0)
    );

    // Pulse start, then observe 40 edges after the capturing edge (edge 0)
    task automatic run_sweep(input bit which, input int restart_at,
                             output int done_edge, output int pulses);
        logic [2:0] cur;
        done_edge = -1;
        pulses    = 0;
        seen.delete();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        cur = which ? vec0 : vec;
        seen.push_back(cur);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = (e == restart_at);
            cur = which ? vec0 : vec;
            if ((which ? busy0 : busy) && (cur != seen[$])) seen.push_back(cur);
            if (which ? done0 : done) begin
                pulses++;
                if (done_edge < 0) done_edge = e;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({vec, busy, done, pass, table_out, mismatch, err_count} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got vec=%h busy=%b done=%b pass=%b tbl=%h mis=%h err=%0d, all must be 0",
                     vec, busy, done, pass, table_out, mismatch, err_count);
        end
        checks++;
        if ({vec0, busy0, done0, pass0, table_out0, mismatch0, err_count0} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs_settle0: got vec=%h busy=%b done=%b tbl=%h, all must be 0",
                     vec0, busy0, done0, table_out0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fxy;
        int de, np;
        mode = 2'd0;
        run_sweep(1'b0, 0, de, np);
        checks++;
        if (de !== 24) begin failures++; $display("FAIL fxy_done_edge: got %0d expected 24", de); end
        checks++;
        if (np !== 1) begin failures++; $display("FAIL fxy_done_pulses: got %0d expected 1", np); end
        checks++;
        if (table_out !== 8'h30) begin failures++; $display("FAIL fxy_table: got %h expected 30", table_out); end
        checks++;
        if (mismatch !== 8'h00) begin failures++; $display("FAIL fxy_mismatch: got %h expected 00", mismatch); end
        checks++;
        if (err_count !== 4'd0) begin failures++; $display("FAIL fxy_err_count: got %0d expected 0", err_count); end
        checks++;
        if (pass !== 1'b1) begin failures++; $display("FAIL fxy_pass: got %b expected 1", pass); end
        checks++;
        if (seen.size() != 8) begin
            failures++;
            $display("FAIL fxy_vec_count: got %0d distinct vectors expected 8", seen.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (seen[i] !== 3'(i)) begin
                    failures++;
                    $display("FAIL fxy_vec_order[%0d]: got %0d expected %0d", i, seen[i], i);
                end
            end
        end
    endtask

    task automatic test_stuck0;
        int de, np;
        mode = 2'd1;
        run_sweep(1'b0, 0, de, np);
`ifdef TRUTH_TABLE_STOP_ON_MISMATCH_EN
        checks++;
        if (de !== 15) begin failures++; $display("FAIL stop_done_edge: got %0d expected 15", de); end
        checks++;
        if (vec !== 3'b100) begin failures++; $display("FAIL stop_vec: got %b expected 100", vec); end
        checks++;
        if (mismatch !== 8'h10) begin failures++; $display("FAIL stop_mismatch: got %h expected 10", mismatch); end
        checks++;
        if (err_count !== 4'd1) begin failures++; $display("FAIL stop_err_count: got %0d expected 1", err_count); end
`else
        checks++;
        if (de !== 24) begin failures++; $display("FAIL stuck0_done_edge: got %0d expected 24", de); end
        checks++;
        if (vec !== 3'd7) begin failures++; $display("FAIL stuck0_vec_hold: got %0d expected 7", vec); end
        checks++;
        if (mismatch !== 8'h30) begin failures++; $display("FAIL stuck0_mismatch: got %h expected 30", mismatch); end
        checks++;
        if (err_count !== 4'd2) begin failures++; $display("FAIL stuck0_err_count: got %0d expected 2", err_count); end
`endif
        checks++;
        if (table_out !== 8'h00) begin failures++; $display("FAIL stuck0_table: got %h expected 00", table_out); end
        checks++;
        if (pass !== 1'b0) begin failures++; $display("FAIL stuck0_pass: got %b expected 0", pass); end
    endtask

    task automatic test_inverted;
        int de, np;
        mode = 2'd2;
        run_sweep(1'b0, 0, de, np);
`ifdef TRUTH_TABLE_STOP_ON_MISMATCH_EN
        checks++;
        if (mismatch !== 8'h01) begin failures++; $display("FAIL inv_mismatch: got %h expected 01", mismatch); end
        checks++;
        if (err_count !== 4'd1) begin failures++; $display("FAIL inv_err_count: got %0d expected 1", err_count); end
        checks++;
        if (table_out !== 8'h01) begin failures++; $display("FAIL inv_table: got %h expected 01", table_out); end
`else
        checks++;
        if (mismatch !== 8'hFF) begin failures++; $display("FAIL inv_mismatch: got %h expected ff", mismatch); end
        checks++;
        if (err_count !== 4'd8) begin failures++; $display("FAIL inv_err_count: got %0d expected 8", err_count); end
        checks++;
        if (table_out !== 8'hCF) begin failures++; $display("FAIL inv_table: got %h expected cf", table_out); end
`endif
        checks++;
        if (pass !== 1'b0) begin failures++; $display("FAIL inv_pass: got %b expected 0", pass); end
    endtask

    task automatic test_back_to_back;
        int de, np;
        mode = 2'd0;
        // start reasserted at edge 6 while both instances are busy
        run_sweep(1'b1, 5, de, np);
        checks++;
        if (de !== 16) begin failures++; $display("FAIL settle0_done_edge: got %0d expected 16", de); end
        checks++;
        if (np !== 1) begin failures++; $display("FAIL settle0_done_pulses: got %0d expected 1", np); end
        checks++;
        if (pass0 !== 1'b1) begin failures++; $display("FAIL settle0_pass: got %b expected 1", pass0); end
        checks++;
        if (table_out0 !== 8'h30) begin failures++; $display("FAIL settle0_table: got %h expected 30", table_out0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL restart_ignored_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int de, np, nd;
        mode = 2'd2;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
`ifdef TRUTH_TABLE_STOP_ON_MISMATCH_EN
        checks++;
        if (err_count !== 4'd1) begin failures++; $display("FAIL mid_err_before_reset: got %0d expected 1", err_count); end
`else
        checks++;
        if (err_count !== 4'd3) begin failures++; $display("FAIL mid_err_before_reset: got %0d expected 3", err_count); end
`endif
        reset = 1'b1;
        #1;
        checks++;
        if ({vec, busy, done, pass, table_out, mismatch, err_count} !== 26'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got vec=%h busy=%b tbl=%h mis=%h err=%0d, all must be 0",
                     vec, busy, table_out, mismatch, err_count);
        end
        @(negedge clk); reset = 1'b0;
        nd = 0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (done || done0) nd++;
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL mid_reset_no_done: got %0d done cycles expected 0", nd); end
        mode = 2'd0;
        run_sweep(1'b0, 0, de, np);
        checks++;
        if (de !== 24) begin failures++; $display("FAIL post_reset_done_edge: got %0d expected 24", de); end
        checks++;
        if ({pass, table_out, err_count} !== {1'b1, 8'h30, 4'd0}) begin
            failures++;
            $display("FAIL post_reset_result: got pass=%b tbl=%h err=%0d expected pass=1 tbl=30 err=0",
                     pass, table_out, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_fxy();
        test_stuck0();
        test_inverted();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
